// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer scheduler.
package vga_pkg;

  localparam int VGA_H_RES        = 640;
  localparam int VGA_V_RES        = 480;
  localparam int VGA_FRAME_PIXELS = VGA_H_RES * VGA_V_RES;

  typedef enum logic [1:0] {
    WAIT_FS = 2'd0,
    FETCH   = 2'd1,
    DONE    = 2'd2
  } fb_state_e;

  typedef logic [23:0] pixel_t;

endpackage

// File: rtl/vga_pix_fifo.sv
// Pixel prefetch FIFO: shift-register organisation so the head entry is
// always a flop. Flush beats push; push and pop together keep the count.
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  pixel_t           wdata_i,
  input  logic             pop_i,
  output pixel_t           head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  pixel_t           data_q   [DEPTH];
  pixel_t           shift_in [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] wr_idx;
  logic             pop_eff;
  logic             push_eff;

  assign empty_o  = (count_q == '0);
  assign pop_eff  = pop_i & ~empty_o & ~flush_i;
  assign push_eff = push_i & ~flush_i & ((count_q != DEPTH_C) | pop_eff);
  // A pop in the same cycle moves the free slot down by one.
  assign wr_idx   = count_q - {{(CNT_W-1){1'b0}}, pop_eff};
  assign head_o   = data_q[0];
  assign count_o  = count_q;

  // Value each slot takes on a pop: its upper neighbour (last slot keeps its own).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) shift_in[i] = data_q[i];
    for (int i = 0; i < DEPTH - 1; i++) shift_in[i] = data_q[i + 1];
  end

  // Occupancy bookkeeping.
  always_comb begin
    count_d = count_q;
    if (flush_i) count_d = '0;
    else if (push_eff && !pop_eff) count_d = count_q + CNT_W'(1);
    else if (pop_eff && !push_eff) count_d = count_q - CNT_W'(1);
  end

  // Count register; reset and flush both empty the FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  // Storage: write the incoming pixel into the first free slot, shift on pop.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_eff && wr_idx == CNT_W'(i)) data_q[i] <= wdata_i;
      else if (pop_eff)                    data_q[i] <= shift_in[i];
    end
  end

endmodule

// File: rtl/vga_fb_scheduler.sv
// Framebuffer port scheduler: raster-order prefetch for scan-out with
// fixed-priority CPU writes in the leftover memory slots.
module vga_fb_scheduler
  import vga_pkg::*;
#(
  parameter int     H_RES    = VGA_H_RES,
  parameter int     V_RES    = VGA_V_RES,
  parameter int     DEPTH    = 8,
  parameter int     ADDR_W   = 19,
  parameter pixel_t BG_COLOR = 24'h000000
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vga_valid,
  input  logic              vga_vsync,
  output pixel_t            vga_data,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  pixel_t            cpu_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output pixel_t            mem_wdata,
  input  pixel_t            mem_rdata,
  output logic              underflow
);

  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] FRAME_C = (ADDR_W + 1)'(H_RES * V_RES);
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

  localparam logic [1:0] ST_WAIT_FS = WAIT_FS;
  localparam logic [1:0] ST_FETCH   = FETCH;
  localparam logic [1:0] ST_DONE    = DONE;

  logic [1:0]       state_q, state_d;
  logic [ADDR_W:0]  fetch_addr_q, fetch_addr_d;
  logic             inflight_q;
  logic             vsync_q;
  logic             underflow_q, underflow_d;

  logic             fs;
  logic             fetch_issue;
  logic             cpu_grant;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   fifo_fill;
  pixel_t           fifo_head;

  assign fs = vga_vsync & ~vsync_q;

  // Entries held plus the read still on its way back.
  assign fifo_fill = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};

  // A frame start suppresses issue so the first read of the frame is address 0.
  assign fetch_issue = reset & ~fs & (state_q == ST_FETCH) &
                       (fetch_addr_q < FRAME_C) & (fifo_fill < DEPTH_C);
  assign cpu_grant   = reset & cpu_valid & ~fetch_issue;
  assign cpu_ready   = cpu_grant;

  // A read returning in a frame-start cycle belongs to the old frame: drop it.
  assign fifo_push = inflight_q & ~fs;
  assign fifo_pop  = vga_valid & ~fifo_empty;

  assign vga_data  = fifo_empty ? BG_COLOR : fifo_head;
  assign underflow = underflow_q;

  vga_pix_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (pclk),
    .rst_n_i (reset),
    .flush_i (fs),
    .push_i  (fifo_push),
    .wdata_i (mem_rdata),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Memory port mux: fetch has priority, CPU gets the remaining slots.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_issue) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr_q[ADDR_W-1:0];
    end else if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Sequencer next state: frame start restarts fetching from address 0.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    underflow_d  = underflow_q | (vga_valid & fifo_empty);
    if (fs) begin
      state_d      = ST_FETCH;
      fetch_addr_d = '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (fetch_issue) fetch_addr_d = fetch_addr_q + (ADDR_W + 1)'(1);
          if (fetch_addr_q == FRAME_C) state_d = ST_DONE;
        end
        ST_DONE:    state_d = ST_DONE;
        default:    state_d = ST_WAIT_FS;
      endcase
    end
  end

  // Control registers. vsync history resets high so leaving reset with vsync
  // high is not mistaken for a frame start.
  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q      <= ST_WAIT_FS;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      vsync_q      <= 1'b1;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= fetch_issue;
      vsync_q      <= vga_vsync;
      underflow_q  <= underflow_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler on a reduced 32x8 raster (40x12 total).
module tb_vga_fb_scheduler;

  localparam int          H   = 32;
  localparam int          V   = 8;
  localparam int          HT  = 40;
  localparam int          VT  = 12;
  localparam int          AW  = 19;
  localparam logic [23:0] BG  = 24'h0A0B0C;

  logic          pclk;
  logic          reset;
  logic          vga_valid;
  logic          vga_vsync;
  logic [23:0]   vga_data;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [23:0]   cpu_wdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic [23:0]   mem_rdata;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  vga_fb_scheduler #(
    .H_RES    (H),
    .V_RES    (V),
    .DEPTH    (8),
    .ADDR_W   (AW),
    .BG_COLOR (BG)
  ) dut (
    .pclk      (pclk),
    .reset     (reset),
    .vga_valid (vga_valid),
    .vga_vsync (vga_vsync),
    .vga_data  (vga_data),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .underflow (underflow)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Memory model: read data equals the address, one cycle after the strobe.
  always @(posedge pclk) begin
    if (mem_en && !mem_we) mem_rdata <= 24'(mem_addr);
  end

  task automatic apply_reset;
    @(negedge pclk);
    reset = 1'b0; vga_valid = 1'b0; cpu_valid = 1'b0; vga_vsync = 1'b1;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(negedge pclk);
    reset = 1'b1;
  endtask

  // Returns inside the frame-start cycle.
  task automatic do_fs;
    @(negedge pclk); vga_vsync = 1'b0;
    @(negedge pclk); vga_vsync = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; vga_valid = 1'b0; vga_vsync = 1'b1;
    cpu_valid = 1'b1; cpu_addr = 19'h00055; cpu_wdata = 24'h000777;
    repeat (3) @(negedge pclk);
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got %b want 0", cpu_ready); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en got en=%b we=%b want 0/0", mem_en, mem_we); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    checks++; if (vga_data !== BG) begin errors++; $display("FAIL reset_vga_data got %h want %h", vga_data, BG); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", underflow); end
    @(negedge pclk); reset = 1'b1; #1;
    checks++; if (cpu_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'h00055 || mem_wdata !== 24'h000777) begin
      errors++; $display("FAIL wait_fs_cpu got rdy=%b we=%b a=%h d=%h want 1 1 00055 000777", cpu_ready, mem_we, mem_addr, mem_wdata);
    end
    @(negedge pclk); cpu_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk); #1;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL wait_fs_nofetch got mem_en=%b want 0", mem_en); end
    end
  endtask

  task automatic test_prefetch;
    apply_reset;
    do_fs;
    for (int k = 0; k < 8; k++) begin
      @(negedge pclk); #1;
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(k)) begin
        errors++; $display("FAIL prefetch_read got en=%b we=%b a=%h want 1 0 %h", mem_en, mem_we, mem_addr, k);
      end
    end
    @(negedge pclk); #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL prefetch_stop got mem_en=%b a=%h want 0", mem_en, mem_addr); end
    @(negedge pclk); cpu_valid = 1'b1; cpu_addr = 19'h00042; cpu_wdata = 24'h00BEEF; #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL prefetch_cpu_ready got %b want 1", cpu_ready); end
    checks++; if (vga_data !== 24'h000000) begin errors++; $display("FAIL prefetch_head got %h want 000000", vga_data); end
    for (int k = 0; k < 16; k++) begin
      @(negedge pclk); cpu_valid = 1'b0; vga_valid = 1'b1; #1;
      checks++; if (vga_data !== 24'(k)) begin errors++; $display("FAIL prefetch_pop got %h want %h", vga_data, 24'(k)); end
    end
    @(negedge pclk); vga_valid = 1'b0;
  endtask

  task automatic test_frame;
    int next_rd;
    int pix;
    int l;
    apply_reset;
    next_rd = 0;
    pix = 0;
    for (int s = 0; s <= VT; s++) begin
      l = (8 + s) % VT;
      for (int h = 0; h < HT; h++) begin
        @(negedge pclk);
        vga_vsync = !(l == 9 || l == 10);
        vga_valid = (l < V) && (h < H);
        #1;
        if (mem_en && !mem_we) begin
          checks++; if (mem_addr !== AW'(next_rd)) begin errors++; $display("FAIL frame_read_addr got %h want %h", mem_addr, next_rd); end
          next_rd++;
        end
        if (vga_valid) begin
          checks++; if (vga_data !== 24'(pix)) begin errors++; $display("FAIL frame_pixel got %h want %h", vga_data, 24'(pix)); end
          pix++;
        end
      end
    end
    vga_valid = 1'b0;
    checks++; if (next_rd != H * V) begin errors++; $display("FAIL frame_read_count got %0d want %0d", next_rd, H * V); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL frame_underflow got %b want 0", underflow); end
  endtask

  task automatic test_cpu_arb;
    logic exp;
    apply_reset;
    do_fs;
    repeat (12) @(negedge pclk);
    for (int k = 0; k < 18; k++) begin
      @(negedge pclk);
      cpu_valid = 1'b1; cpu_addr = 19'h00777; cpu_wdata = 24'h111111;
      vga_valid = (k < 16);
      #1;
      exp = (k == 0 || k == 17);
      checks++; if (cpu_ready !== exp || mem_we !== exp) begin
        errors++; $display("FAIL arb_cycle%0d got rdy=%b we=%b want %b", k, cpu_ready, mem_we, exp);
      end
    end
    @(negedge pclk); cpu_addr = 19'h00123; cpu_wdata = 24'hABCDEF; vga_valid = 1'b0; #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'h00123 || mem_wdata !== 24'hABCDEF || cpu_ready !== 1'b1) begin
      errors++; $display("FAIL arb_hblank_write got en=%b we=%b a=%h d=%h rdy=%b want 1 1 00123 abcdef 1", mem_en, mem_we, mem_addr, mem_wdata, cpu_ready);
    end
    @(negedge pclk); cpu_valid = 1'b0;
  endtask

  task automatic test_underflow;
    logic [23:0] exp;
    apply_reset;
    do_fs;
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk); vga_valid = 1'b1; #1;
      exp = (k < 2) ? BG : 24'(k - 2);
      checks++; if (vga_data !== exp) begin errors++; $display("FAIL underflow_data%0d got %h want %h", k, vga_data, exp); end
      checks++; if (underflow !== (k >= 1)) begin errors++; $display("FAIL underflow_flag%0d got %b want %b", k, underflow, (k >= 1)); end
    end
    @(negedge pclk); vga_valid = 1'b0;
    do_fs;
    @(negedge pclk); #1;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b want 1", underflow); end
    checks++; if (vga_data !== BG) begin errors++; $display("FAIL underflow_flushed got %h want %h", vga_data, BG); end
  endtask

  task automatic test_fs_drop;
    apply_reset;
    do_fs;
    @(negedge pclk); vga_vsync = 1'b0; #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== '0) begin errors++; $display("FAIL drop_first_read got en=%b a=%h want 1 0", mem_en, mem_addr); end
    @(negedge pclk); vga_vsync = 1'b1; #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL drop_fs_no_issue got mem_en=%b want 0", mem_en); end
    @(negedge pclk); #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL drop_restart_addr got en=%b we=%b a=%h want 1 0 0", mem_en, mem_we, mem_addr); end
    checks++; if (vga_data !== BG) begin errors++; $display("FAIL drop_fifo_empty got %h want %h", vga_data, BG); end
    @(negedge pclk); #1;
    checks++; if (vga_data !== BG || mem_addr !== 19'h1) begin errors++; $display("FAIL drop_second got d=%h a=%h want %h 1", vga_data, mem_addr, BG); end
    @(negedge pclk); #1;
    checks++; if (vga_data !== 24'h000000) begin errors++; $display("FAIL drop_first_pixel got %h want 000000", vga_data); end
  endtask

  task automatic test_reset_midline;
    apply_reset;
    do_fs;
    repeat (12) @(negedge pclk);
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk); vga_valid = 1'b1;
    end
    @(negedge pclk); reset = 1'b0; cpu_valid = 1'b1; #1;
    checks++; if (mem_en !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL midreset_gate got en=%b rdy=%b want 0 0", mem_en, cpu_ready); end
    @(negedge pclk); reset = 1'b1; vga_valid = 1'b0; cpu_valid = 1'b0; #1;
    checks++; if (vga_data !== BG) begin errors++; $display("FAIL midreset_vga_data got %h want %h", vga_data, BG); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL midreset_mem got en=%b a=%h d=%h want 0", mem_en, mem_addr, mem_wdata); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL midreset_underflow got %b want 0", underflow); end
    for (int k = 0; k < 30; k++) begin
      @(negedge pclk); #1;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL midreset_nofetch got mem_en=%b want 0", mem_en); end
    end
    do_fs;
    @(negedge pclk); #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL midreset_refetch got en=%b we=%b a=%h want 1 0 0", mem_en, mem_we, mem_addr); end
  endtask

  initial begin
    test_reset;
    test_prefetch;
    test_frame;
    test_cpu_arb;
    test_underflow;
    test_fs_drop;
    test_reset_midline;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_scheduler.md
# vga_fb_scheduler

Sequences and arbitrates a single-port 24-bit framebuffer memory between the VGA scan-out path and a CPU write port. It prefetches pixels in raster order into a small FIFO so that `vga_data` is valid whenever the VGA timing generator asserts `valid`. CPU writes use only the memory slots that scan-out does not need. It sits between the SoC bus bridge, the framebuffer RAM and the VGA timing generator (`vga_ctrl`).

## Interface
- `H_RES`, default 640: active pixels per line.
- `V_RES`, default 480: active lines per frame.
- `DEPTH`, default 8: prefetch FIFO entries; must be a power of 2 and at least 4.
- `ADDR_W`, default 19: memory address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES.
- `BG_COLOR`, default 24'h000000: pixel value driven on underflow.

Ports:
- `pclk` in 1: pixel clock.
- `reset` in 1: reset, synchronous, active-low; clock `pclk`.
- `vga_valid` in 1: active-pixel flag from the timing generator; pops one pixel per cycle.
- `vga_vsync` in 1: vsync from the timing generator, low during the sync pulse.
- `vga_data` out 24: current pixel {R,G,B}.
- `cpu_valid` in 1: CPU write request.
- `cpu_ready` out 1: write accepted this cycle.
- `cpu_addr` in ADDR_W: write address.
- `cpu_wdata` in 24: write data.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out 24: write data.
- `mem_rdata` in 24: read data, valid exactly 1 cycle after a read strobe.
- `underflow` out 1: sticky flag; set when `vga_valid` is seen with the FIFO empty.

## Operation
- Frame start (`fs`) is a `vga_vsync` 0→1 edge, detected with a registered copy of `vga_vsync`. On `fs`:
  - FIFO flushed.
  - `fetch_addr` := 0.
  - Any in-flight read tagged for drop.
  - `underflow` is **not** cleared.
- FSM states:
  - `WAIT_FS`: entered at reset. No fetch; CPU owns every slot. `fs` → `FETCH`.
  - `FETCH`: issues reads. When `fetch_addr` reaches H_RES·V_RES → `DONE`. `fs` → `FETCH` with state restarted.
  - `DONE`: no fetch; CPU owns every slot. `fs` → `FETCH`.
- Fetch issue condition: state `FETCH` and `fifo_count + inflight < DEPTH`. On issue: `mem_en`=1, `mem_we`=0, `mem_addr`=`fetch_addr`, then `fetch_addr`++ and `inflight` set for one cycle.
- Arbitration is fixed priority: fetch first, then CPU.
  - `cpu_ready` = `cpu_valid` & !fetch_issue (combinational).
  - On grant: `mem_en`=1, `mem_we`=1, `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`.
  - CPU starvation during active lines is accepted by design; the CPU is served during horizontal and vertical blanking.
- Read return: the cycle after issue, `mem_rdata` is pushed to the FIFO unless the read was tagged for drop.
- Pop: when `vga_valid`=1 and the FIFO is non-empty. Push and pop in the same cycle are both honoured; the count is unchanged.
- `vga_data` = FIFO head when non-empty, else BG_COLOR. It is combinational from the head register.
- Underflow: when `vga_valid`=1 and the FIFO is empty, `underflow` := 1 and no pop occurs. `fetch_addr` is not adjusted; the frame shifts until the next `fs`.

## Timing
- Reset values:
  - FSM = `WAIT_FS`; FIFO empty; `fetch_addr`=0; `inflight`=0; `underflow`=0.
  - `mem_en`/`mem_we`=0; `cpu_ready`=0.
  - `vga_data`=BG_COLOR; `mem_addr`/`mem_wdata`=0 when `mem_en`=0.
- Reset asserted mid-frame aborts immediately and the block waits for the next `fs`.
- Read-to-FIFO latency: 2 cycles (issue at cycle N, push at N+1, visible on `vga_data` at N+2).
- From `fs`, the FIFO is full after DEPTH+1 cycles. Vblank is far longer than this, so the first active pixel is never starved.
- `fs` in the same cycle as a push: the flush wins and the pushed data is dropped.
- `fs` in the same cycle as a fetch issue: no issue; the first read goes out the next cycle at address 0.
- `fetch_addr` is ADDR_W+1 bits wide, to compare against H_RES·V_RES without overflow.
- `fifo_count` is log2(DEPTH)+1 bits wide.

## Structure
- Shared package `vga_pkg`:
  - H_RES, V_RES and FRAME_PIXELS constants.
  - FSM state enum {WAIT_FS, FETCH, DONE}.
  - 24-bit pixel typedef.
- Sub-module `vga_pix_fifo`: synchronous FIFO, DEPTH×24, registered head, with `count`, `flush`, and simultaneous push/pop support.
- The FSM, arbiter and edge detector live in the top level.

## Test plan
- Reset, then `fs` with `vga_valid` held 0 and memory returning data = address → FIFO holds pixels 0..7 after 9 cycles; reads stop at `mem_addr`=8; `cpu_ready`=1 on the next `cpu_valid`.
- Full 640×480 frame using the standard 800×525 timing → `vga_data` sequence equals addresses 0..307199 in order; `underflow` stays 0; FSM reaches `DONE` after the last read.
- `cpu_valid` held high during an active line → `cpu_ready`=0 on every cycle with a fetch issue; a write to 0x00123 with data 0xABCDEF during hblank appears as a `mem_we`=1 cycle with those values.
- `vga_valid` forced high for 20 cycles right after `fs` (only 8 prefetched) → `underflow` latches to 1 and `vga_data`=BG_COLOR on each empty cycle; the flag survives the next `fs`.
- `fs` in the cycle a read returns → that data is dropped, the FIFO is empty, and the next read address is 0.
- Reset asserted mid-line, then deasserted → all outputs are at their reset values, and no fetch occurs before the next `fs`.
